// File: rtl/seg_display_scheduler.sv
// Six-digit seven-segment scheduler: status channel A, preemptive blinking
// alert channel B with a tick-based hold, and a PWM brightness gate.
//
// Ports:
//   clk        system clock; every register updates on its rising edge
//   rst        synchronous active-low reset
//   tick       one-cycle 1 Hz pulse that counts down the alert hold
//   duty       brightness; a digit is lit while pwm_cnt < duty_latched
//   a_valid    status update (always accepted outside reset)
//   a_digits   status digits, [3:0]=HEX0 .. [23:20]=HEX5
//   a_ready    1 outside reset
//   b_valid    alert request; must be held until b_ready
//   b_digits   alert digits, same packing as a_digits
//   b_ready    1 outside reset while no alert is showing
//   digits_out registered digit codes to the six decoders
//   owner      0=IDLE, 1=SHOW_A, 2=SHOW_B
//   alert_done one-cycle pulse when an alert leaves the display
module seg_display_scheduler #(
  parameter int unsigned PWM_PERIOD = 10,
  parameter int unsigned HOLD_TICKS = 3,
  parameter logic [3:0]  BLANK_CODE = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  duty,
  input  logic        a_valid,
  input  logic [23:0] a_digits,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [23:0] b_digits,
  output logic        b_ready,
  output logic [23:0] digits_out,
  output logic [1:0]  owner,
  output logic        alert_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_e;

  localparam logic [23:0] ALL_BLANK = {6{BLANK_CODE}};
  localparam logic [3:0]  PWM_LAST  = 4'(PWM_PERIOD - 1);
  localparam logic [3:0]  HOLD_INIT = 4'(HOLD_TICKS);

  state_e      state_q, state_d;
  logic [23:0] a_buf_q, a_buf_d;
  logic        a_vld_q, a_vld_d;
  logic [23:0] b_buf_q, b_buf_d;
  logic [3:0]  hold_q, hold_d;
  logic        blink_q, blink_d;
  logic        done_q, done_d;
  logic [3:0]  pwm_q, pwm_d;
  logic [3:0]  duty_q, duty_d;
  logic [23:0] dig_q, dig_d;

  logic        a_acc;
  logic        b_acc;
  logic        wrap;
  logic        lit;
  logic [23:0] src;

  assign a_ready = rst;
  assign b_ready = rst && (state_q != SHOW_B);
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  // Arbitration and alert countdown
  always_comb begin
    state_d = state_q;
    a_buf_d = a_buf_q;
    a_vld_d = a_vld_q;
    b_buf_d = b_buf_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    done_d  = 1'b0;

    if (a_acc) begin
      a_buf_d = a_digits;
      a_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (a_acc) state_d = SHOW_A;
      end
      SHOW_A: begin
        state_d = SHOW_A;
      end
      SHOW_B: begin
        if (tick) begin
          blink_d = ~blink_q;
          // hold_q==0 cannot occur here; treating it
          // as the last tick avoids a stuck alert.
          if (hold_q <= 4'd1) begin
            hold_d  = 4'd0;
            state_d = a_vld_d ? SHOW_A : IDLE;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh alert overrides everything above,
    // including a tick in the same cycle.
    if (b_acc) begin
      b_buf_d = b_digits;
      hold_d  = HOLD_INIT;
      blink_d = 1'b0;
      state_d = SHOW_B;
    end
  end

  // Source selection
  always_comb begin
    src = ALL_BLANK;
    unique case (state_q)
      IDLE:    src = ALL_BLANK;
      SHOW_A:  src = a_buf_q;
      SHOW_B:  src = blink_q ? ALL_BLANK : b_buf_q;
      default: src = ALL_BLANK;
    endcase
  end

  // PWM gate; duty only changes at a frame boundary
  always_comb begin
    wrap   = (pwm_q == PWM_LAST);
    pwm_d  = wrap ? 4'd0 : pwm_q + 4'd1;
    duty_d = wrap ? duty : duty_q;
    lit    = (pwm_q < duty_q);
    dig_d  = lit ? src : ALL_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_buf_q <= 24'd0;
      a_vld_q <= 1'b0;
      b_buf_q <= 24'd0;
      hold_q  <= 4'd0;
      blink_q <= 1'b0;
      done_q  <= 1'b0;
      pwm_q   <= 4'd0;
      duty_q  <= 4'd0;
      dig_q   <= ALL_BLANK;
    end else begin
      state_q <= state_d;
      a_buf_q <= a_buf_d;
      a_vld_q <= a_vld_d;
      b_buf_q <= b_buf_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
      dig_q   <= dig_d;
    end
  end

  assign digits_out = dig_q;
  assign owner      = state_q;
  assign alert_done = done_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed testbench for seg_display_scheduler.
// Ends with one TB_RESULT summary line.
module tb_seg_display_scheduler;

  localparam logic [23:0] BL = 24'hAAAAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  duty = 4'd0;
  logic        a_valid = 1'b0;
  logic [23:0] a_digits = 24'd0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [23:0] b_digits = 24'd0;
  logic        b_ready;
  logic [23:0] digits_out;
  logic [1:0]  owner;
  logic        alert_done;

  int checks = 0;
  int failures = 0;
  int pcnt = 0;

  seg_display_scheduler #(
    .PWM_PERIOD(10),
    .HOLD_TICKS(3),
    .BLANK_CODE(4'd10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .duty(duty),
    .a_valid(a_valid),
    .a_digits(a_digits),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_digits(b_digits),
    .b_ready(b_ready),
    .digits_out(digits_out),
    .owner(owner),
    .alert_done(alert_done)
  );

  always #5 clk = ~clk;

  // Expected PWM frame position after each edge
  always @(posedge clk) begin
    if (!rst) pcnt <= 0;
    else pcnt <= (pcnt == 9) ? 0 : pcnt + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    duty = 4'd10;
    step(2);
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner); end
    checks++; if (digits_out !== BL) begin failures++; $display("FAIL rst_digits got=%h exp=%h", digits_out, BL); end
    checks++; if (alert_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", alert_done); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
    rst = 1'b1;
    step(10);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL run_a_ready got=%b exp=1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL run_b_ready got=%b exp=1", b_ready); end
  endtask

  task automatic test_show_a();
    a_digits = 24'h000003;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL a_owner got=%0d exp=1", owner); end
    checks++; if (digits_out !== BL) begin failures++; $display("FAIL a_latency got=%h exp=%h", digits_out, BL); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (digits_out !== 24'h000003) begin failures++; $display("FAIL a_digits[%0d] got=%h exp=000003", i, digits_out); end
    end
  endtask

  task automatic test_pwm();
    int w;
    duty = 4'd4;
    a_digits = 24'h000005;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    w = 0;
    while (pcnt != 0 && w < 12) begin
      step();
      w++;
    end
    checks++; if (pcnt != 0) begin failures++; $display("FAIL pwm_align got=%0d exp=0", pcnt); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (digits_out !== ((k < 4) ? 24'h000005 : BL)) begin
        failures++;
        $display("FAIL pwm4[%0d] got=%h exp=%h", k, digits_out, (k < 4) ? 24'h000005 : BL);
      end
      if (k == 5) duty = 4'd7;
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (digits_out !== ((k < 7) ? 24'h000005 : BL)) begin
        failures++;
        $display("FAIL pwm7[%0d] got=%h exp=%h", k, digits_out, (k < 7) ? 24'h000005 : BL);
      end
    end
  endtask

  task automatic test_alert();
    duty = 4'd10;
    a_digits = 24'h000003;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step(11);
    checks++; if (digits_out !== 24'h000003) begin failures++; $display("FAIL al_pre got=%h exp=000003", digits_out); end
    b_digits = 24'hCDEFA7;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL al_owner got=%0d exp=2", owner); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL al_b_ready got=%b exp=0", b_ready); end
    step();
    checks++; if (digits_out !== 24'hCDEFA7) begin failures++; $display("FAIL al_on0 got=%h exp=cdefa7", digits_out); end
    step(3);
    do_tick();
    step();
    checks++; if (digits_out !== BL) begin failures++; $display("FAIL al_off1 got=%h exp=%h", digits_out, BL); end
    step(2);
    do_tick();
    step();
    checks++; if (digits_out !== 24'hCDEFA7) begin failures++; $display("FAIL al_on2 got=%h exp=cdefa7", digits_out); end
    checks++; if (alert_done !== 1'b0) begin failures++; $display("FAIL al_done_early got=%b exp=0", alert_done); end
    do_tick();
    checks++; if (alert_done !== 1'b1) begin failures++; $display("FAIL al_done got=%b exp=1", alert_done); end
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL al_exit_owner got=%0d exp=1", owner); end
    step();
    checks++; if (alert_done !== 1'b0) begin failures++; $display("FAIL al_done_pulse got=%b exp=0", alert_done); end
    checks++; if (digits_out !== 24'h000003) begin failures++; $display("FAIL al_restore got=%h exp=000003", digits_out); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL al_b_ready_back got=%b exp=1", b_ready); end
  endtask

  task automatic test_back_to_back();
    b_digits = 24'hCDEFA7;
    b_valid = 1'b1;
    step();
    b_digits = 24'h0E0E0E;
    a_digits = 24'h000001;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL bb_owner got=%0d exp=2", owner); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL bb_b_ready got=%b exp=0", b_ready); end
    checks++; if (digits_out !== 24'hCDEFA7) begin failures++; $display("FAIL bb_keep got=%h exp=cdefa7", digits_out); end
    do_tick();
    step();
    do_tick();
    step();
    checks++; if (digits_out !== 24'hCDEFA7) begin failures++; $display("FAIL bb_keep2 got=%h exp=cdefa7", digits_out); end
    do_tick();
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL bb_exit_owner got=%0d exp=1", owner); end
    checks++; if (alert_done !== 1'b1) begin failures++; $display("FAIL bb_done got=%b exp=1", alert_done); end
    step();
    b_valid = 1'b0;
    checks++; if (digits_out !== 24'h000001) begin failures++; $display("FAIL bb_new_a got=%h exp=000001", digits_out); end
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL bb_held_b got=%0d exp=2", owner); end
    step();
    checks++; if (digits_out !== 24'h0E0E0E) begin failures++; $display("FAIL bb_held_digits got=%h exp=0e0e0e", digits_out); end
  endtask

  task automatic test_tick_coincident();
    do_tick();
    step();
    do_tick();
    step();
    do_tick();
    step();
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL tc_pre_owner got=%0d exp=1", owner); end
    b_digits = 24'hCDEFA7;
    b_valid = 1'b1;
    tick = 1'b1;
    step();
    b_valid = 1'b0;
    tick = 1'b0;
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL tc_owner got=%0d exp=2", owner); end
    step();
    checks++; if (digits_out !== 24'hCDEFA7) begin failures++; $display("FAIL tc_blink got=%h exp=cdefa7", digits_out); end
    do_tick();
    step();
    do_tick();
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL tc_tick2_owner got=%0d exp=2", owner); end
    checks++; if (alert_done !== 1'b0) begin failures++; $display("FAIL tc_tick2_done got=%b exp=0", alert_done); end
    step();
    do_tick();
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL tc_tick3_owner got=%0d exp=1", owner); end
    checks++; if (alert_done !== 1'b1) begin failures++; $display("FAIL tc_tick3_done got=%b exp=1", alert_done); end
  endtask

  task automatic test_reset_mid();
    step();
    b_digits = 24'hCDEFA7;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    do_tick();
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL rm_pre_owner got=%0d exp=2", owner); end
    rst = 1'b0;
    step();
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rm_owner got=%0d exp=0", owner); end
    checks++; if (digits_out !== BL) begin failures++; $display("FAIL rm_digits got=%h exp=%h", digits_out, BL); end
    checks++; if (alert_done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", alert_done); end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (owner !== 2'd0 || alert_done !== 1'b0) begin failures++; $display("FAIL rm_idle[%0d] owner=%0d done=%b exp owner=0 done=0", i, owner, alert_done); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    step();
    test_reset();
    test_show_a();
    test_pwm();
    test_alert();
    test_back_to_back();
    test_tick_coincident();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
